// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI device: FSM state encoding,
// command decode bit and the byte shifted out when the TX FIFO runs dry.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WRITE,
    READ
  } spi_dev_state_e;

  localparam int          CmdReadBit = 7;
  localparam logic [7:0]  IdleByte   = 8'hFF;

endpackage

// File: rtl/spi_device_fifo.sv
// Byte-wide circular FIFO with valid/ready on both sides. A push into a full
// FIFO is accepted when a pop happens in the same cycle.
module spi_device_fifo #(
  parameter int Depth = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] wdata_i,
  input  logic       wvalid_i,
  output logic       wready_o,
  output logic [7:0] rdata_o,
  output logic       rvalid_o,
  input  logic       rready_i
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            full, empty, push, pop;

  assign full     = (cnt_q == CntW'(Depth));
  assign empty    = (cnt_q == '0);
  assign pop      = rready_i && !empty;
  assign push     = wvalid_i && (!full || pop);
  assign wready_o = !full;
  assign rvalid_o = !empty;
  assign rdata_o  = mem_q[rd_ptr_q];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage has no reset; only pointers and count define what is valid,
  // so clearing them empties the FIFO without a reset fan-out to every entry.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/spi_device.sv
// SPI target for a 3-wire half-duplex mode-0 bus: pins are oversampled in the
// clk_i domain, a command byte selects a write (to RX FIFO) or read (from TX FIFO).
module spi_device
  import spi_pkg::*;
#(
  parameter int FifoDepth  = 3,
  parameter int SyncStages = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_cs_i,
  input  logic       spi_sclk_i,
  input  logic       spi_sdio_i,
  output logic       spi_sdio_o,
  output logic       spi_sdioz_o,
  output logic [7:0] rx_rdata_o,
  output logic       rx_rvalid_o,
  input  logic       rx_rready_i,
  input  logic [7:0] tx_wdata_i,
  input  logic       tx_wvalid_i,
  output logic       tx_wready_o,
  output logic       busy_o,
  output logic       err_ovf_o,
  output logic       err_udf_o
);

  logic [SyncStages-1:0] cs_sync_q, sclk_sync_q, sdio_sync_q;
  logic                  cs_prev_q, sclk_prev_q;
  logic                  cs_s, sclk_s, sdio_s;
  logic                  cs_fall, cs_rise, sclk_rise, sclk_fall;

  // cs resets to its inactive level so leaving reset never fakes a select.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      sdio_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SyncStages-2:0], spi_cs_i};
      sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], spi_sclk_i};
      sdio_sync_q <= {sdio_sync_q[SyncStages-2:0], spi_sdio_i};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign cs_s      = cs_sync_q[SyncStages-1];
  assign sclk_s    = sclk_sync_q[SyncStages-1];
  assign sdio_s    = sdio_sync_q[SyncStages-1];
  assign cs_fall   = !cs_s && cs_prev_q;
  assign cs_rise   = cs_s && !cs_prev_q;
  assign sclk_rise = sclk_s && !sclk_prev_q;
  assign sclk_fall = !sclk_s && sclk_prev_q;

  spi_dev_state_e state_q;
  logic [2:0]     bit_cnt_q;
  logic [6:0]     shift_q, tx_shift_q;
  logic           sdio_o_q, sdioz_q, err_ovf_q, err_udf_q;

  logic [7:0] rx_byte_d, tx_byte_d, tx_rdata;
  logic       byte_done, rx_push, rx_wready, rx_pop, tx_pop_req, tx_rvalid;

  assign rx_byte_d  = {shift_q, sdio_s};
  assign byte_done  = sclk_rise && (bit_cnt_q == 3'd7);
  // A byte completing together with cs rising is still delivered.
  assign rx_push    = (state_q == WRITE) && byte_done;
  assign rx_pop     = rx_rready_i && rx_rvalid_o;
  assign tx_pop_req = (state_q == READ) && sclk_fall && (bit_cnt_q == 3'd0) && !cs_rise;
  assign tx_byte_d  = tx_rvalid ? tx_rdata : IdleByte;

  spi_device_fifo #(.Depth(FifoDepth)) u_rx_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wdata_i  (rx_byte_d),
    .wvalid_i (rx_push),
    .wready_o (rx_wready),
    .rdata_o  (rx_rdata_o),
    .rvalid_o (rx_rvalid_o),
    .rready_i (rx_rready_i)
  );

  spi_device_fifo #(.Depth(FifoDepth)) u_tx_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wdata_i  (tx_wdata_i),
    .wvalid_i (tx_wvalid_i),
    .wready_o (tx_wready_o),
    .rdata_o  (tx_rdata),
    .rvalid_o (tx_rvalid),
    .rready_i (tx_pop_req)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      sdio_o_q   <= 1'b0;
      sdioz_q    <= 1'b1;
      err_ovf_q  <= 1'b0;
      err_udf_q  <= 1'b0;
    end else begin
      err_ovf_q <= rx_push && !rx_wready && !rx_pop;
      err_udf_q <= tx_pop_req && !tx_rvalid;

      // The counter advances on rises in every active state and wraps 7->0,
      // so in READ a fall with count 0 marks the start of a new byte.
      if (sclk_rise && state_q != IDLE) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shift_q   <= rx_byte_d[6:0];
      end

      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= CMD;
            bit_cnt_q <= '0;
          end
        end
        CMD: begin
          if (byte_done) state_q <= rx_byte_d[CmdReadBit] ? READ : WRITE;
        end
        WRITE: ;
        READ: begin
          if (sclk_fall) begin
            sdioz_q <= 1'b0;
            if (bit_cnt_q == 3'd0) begin
              sdio_o_q   <= tx_byte_d[7];
              tx_shift_q <= tx_byte_d[6:0];
            end else begin
              sdio_o_q   <= tx_shift_q[6];
              tx_shift_q <= {tx_shift_q[5:0], 1'b0};
            end
          end
        end
      endcase

      if (cs_rise) begin
        state_q  <= IDLE;
        sdioz_q  <= 1'b1;
        sdio_o_q <= 1'b0;
      end
    end
  end

  assign spi_sdio_o  = sdio_o_q;
  assign spi_sdioz_o = sdioz_q;
  assign busy_o      = (state_q != IDLE);
  assign err_ovf_o   = err_ovf_q;
  assign err_udf_o   = err_udf_q;

endmodule

// File: tb/tb_spi_device.sv
// Directed bench for spi_device: a bit-banged mode-0 host plus a byte
// scoreboard queue for RX pops and host-sampled read data.
module tb_spi_device;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_cs, spi_sclk, spi_sdio;
  logic       spi_sdio_o, spi_sdioz_o;
  logic [7:0] rx_rdata_o;
  logic       rx_rvalid_o, rx_rready;
  logic [7:0] tx_wdata;
  logic       tx_wvalid, tx_wready_o;
  logic       busy_o, err_ovf_o, err_udf_o;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  int udf_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_device #(.FifoDepth(3), .SyncStages(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .spi_cs_i    (spi_cs),
    .spi_sclk_i  (spi_sclk),
    .spi_sdio_i  (spi_sdio),
    .spi_sdio_o  (spi_sdio_o),
    .spi_sdioz_o (spi_sdioz_o),
    .rx_rdata_o  (rx_rdata_o),
    .rx_rvalid_o (rx_rvalid_o),
    .rx_rready_i (rx_rready),
    .tx_wdata_i  (tx_wdata),
    .tx_wvalid_i (tx_wvalid),
    .tx_wready_o (tx_wready_o),
    .busy_o      (busy_o),
    .err_ovf_o   (err_ovf_o),
    .err_udf_o   (err_udf_o)
  );

  // Error outputs are single-cycle pulses, so counting high negedges counts pulses.
  always @(negedge clk) begin
    if (err_ovf_o) ovf_cnt++;
    if (err_udf_o) udf_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives nbits of b MSB first; samples device sdio just before each rise.
  task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_sclk = 1'b0;
      spi_sdio = b[i];
      wait_clk(5);
      got[i] = spi_sdio_o;
      spi_sclk = 1'b1;
      wait_clk(5);
    end
  endtask

  task automatic xfer_byte(input logic [7:0] b, input string tag, input logic exp_z,
                           output logic [7:0] got);
    spi_sclk = 1'b0;
    spi_sdio = b[7];
    wait_clk(5);
    check({tag, "_sdioz"}, {31'd0, spi_sdioz_o}, {31'd0, exp_z});
    xfer_bits(b, 8, got);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_clk(5);
  endtask

  task automatic cs_high();
    spi_cs = 1'b1;
    wait_clk(5);
    spi_sclk = 1'b0;
    wait_clk(5);
  endtask

  task automatic tx_push(input logic [7:0] b);
    tx_wdata  = b;
    tx_wvalid = 1'b1;
    wait_clk(1);
    tx_wvalid = 1'b0;
  endtask

  task automatic drain_rx(input string tag);
    logic [7:0] exp;
    while (exp_q.size() > 0) begin
      for (int k = 0; k < 20 && !rx_rvalid_o; k++) wait_clk(1);
      exp = exp_q.pop_front();
      check({tag, "_rvalid"}, {31'd0, rx_rvalid_o}, 32'd1);
      check({tag, "_rdata"}, {24'd0, rx_rdata_o}, {24'd0, exp});
      rx_rready = 1'b1;
      wait_clk(1);
      rx_rready = 1'b0;
    end
    check({tag, "_rx_empty"}, {31'd0, rx_rvalid_o}, 32'd0);
  endtask

  initial begin
    logic [7:0] got;
    int ovf0, udf0;

    rst_n = 1'b0; spi_cs = 1'b1; spi_sclk = 1'b0; spi_sdio = 1'b0;
    rx_rready = 1'b0; tx_wdata = '0; tx_wvalid = 1'b0;
    wait_clk(3);
    check("rst_sdio",   {31'd0, spi_sdio_o},  32'd0);
    check("rst_sdioz",  {31'd0, spi_sdioz_o}, 32'd1);
    check("rst_rvalid", {31'd0, rx_rvalid_o}, 32'd0);
    check("rst_wready", {31'd0, tx_wready_o}, 32'd1);
    check("rst_busy",   {31'd0, busy_o},      32'd0);
    check("rst_errs",   {30'd0, err_ovf_o, err_udf_o}, 32'd0);
    rst_n = 1'b1;
    wait_clk(3);

    // Write 0xA5, 0x3C
    cs_low();
    xfer_byte(8'h00, "wr_cmd", 1'b1, got);
    check("wr_busy", {31'd0, busy_o}, 32'd1);
    exp_q.push_back(8'hA5);
    xfer_byte(8'hA5, "wr_b0", 1'b1, got);
    exp_q.push_back(8'h3C);
    xfer_byte(8'h3C, "wr_b1", 1'b1, got);
    cs_high();
    check("wr_idle", {31'd0, busy_o}, 32'd0);
    check("wr_sdioz_end", {31'd0, spi_sdioz_o}, 32'd1);
    drain_rx("wr");

    // Read 0x12, 0x34 with TX filled to the brim; extra push must be dropped
    udf0 = udf_cnt;
    tx_push(8'h12); exp_q.push_back(8'h12);
    tx_push(8'h34); exp_q.push_back(8'h34);
    check("tx_not_full", {31'd0, tx_wready_o}, 32'd1);
    tx_push(8'h56); exp_q.push_back(8'h56);
    check("tx_full", {31'd0, tx_wready_o}, 32'd0);
    tx_push(8'h77);
    cs_low();
    xfer_byte(8'h80, "rd_cmd", 1'b1, got);
    xfer_byte(8'h00, "rd_b0", 1'b0, got);
    check("rd_b0_data", {24'd0, got}, {24'd0, exp_q.pop_front()});
    xfer_byte(8'h00, "rd_b1", 1'b0, got);
    check("rd_b1_data", {24'd0, got}, {24'd0, exp_q.pop_front()});
    check("rd_sdioz_held", {31'd0, spi_sdioz_o}, 32'd0);
    cs_high();
    check("rd_sdioz_end", {31'd0, spi_sdioz_o}, 32'd1);
    cs_low();
    xfer_byte(8'h80, "rd2_cmd", 1'b1, got);
    xfer_byte(8'h00, "rd2_b0", 1'b0, got);
    check("rd2_b0_data", {24'd0, got}, {24'd0, exp_q.pop_front()});
    cs_high();
    check("rd_no_udf", udf_cnt - udf0, 32'd0);

    // Overflow: 5 bytes into a 3-deep RX FIFO with nobody popping
    ovf0 = ovf_cnt;
    cs_low();
    xfer_byte(8'h00, "ovf_cmd", 1'b1, got);
    for (int b = 1; b <= 5; b++) begin
      if (b <= 3) exp_q.push_back(8'(b));
      xfer_byte(8'(b), "ovf_b", 1'b1, got);
    end
    cs_high();
    check("ovf_pulses", ovf_cnt - ovf0, 32'd2);
    drain_rx("ovf");

    // Underflow: read with empty TX
    udf0 = udf_cnt;
    cs_low();
    xfer_byte(8'h80, "udf_cmd", 1'b1, got);
    xfer_byte(8'h00, "udf_b0", 1'b0, got);
    cs_high();
    check("udf_data", {24'd0, got}, 32'hFF);
    check("udf_pulses", udf_cnt - udf0, 32'd1);

    // Abort mid-byte, then a clean write
    cs_low();
    xfer_byte(8'h00, "abt_cmd", 1'b1, got);
    xfer_bits(8'hF0, 4, got);
    cs_high();
    wait_clk(5);
    check("abt_no_push", {31'd0, rx_rvalid_o}, 32'd0);
    cs_low();
    xfer_byte(8'h00, "abt2_cmd", 1'b1, got);
    exp_q.push_back(8'h5A);
    xfer_byte(8'h5A, "abt2_b0", 1'b1, got);
    cs_high();
    drain_rx("abt");

    // Reset in the middle of a read with two bytes queued
    tx_push(8'hAA);
    tx_push(8'hBB);
    cs_low();
    xfer_byte(8'h80, "rr_cmd", 1'b1, got);
    xfer_bits(8'h00, 4, got);
    rst_n = 1'b0;
    wait_clk(1);
    check("rr_sdio",   {31'd0, spi_sdio_o},  32'd0);
    check("rr_sdioz",  {31'd0, spi_sdioz_o}, 32'd1);
    check("rr_rvalid", {31'd0, rx_rvalid_o}, 32'd0);
    check("rr_wready", {31'd0, tx_wready_o}, 32'd1);
    check("rr_busy",   {31'd0, busy_o},      32'd0);
    check("rr_errs",   {30'd0, err_ovf_o, err_udf_o}, 32'd0);
    rst_n = 1'b1;
    cs_high();
    udf0 = udf_cnt;
    cs_low();
    xfer_byte(8'h80, "rr2_cmd", 1'b1, got);
    xfer_byte(8'h00, "rr2_b0", 1'b0, got);
    cs_high();
    check("rr2_data", {24'd0, got}, 32'hFF);
    check("rr2_udf", udf_cnt - udf0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
